// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - EX-stage to mult/div sequencer bundle with HI/LO readback
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [1:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             id_uses_hilo;
  logic             busy;
  logic             hilo_stall;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op_code, op_a, op_b, id_uses_hilo,
    input  busy, hilo_stall, done, div_zero, hi, lo
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, id_uses_hilo,
    output busy, hilo_stall, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - bit-serial MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  logic             start;
  logic             div_req;
  logic             zero_div;
  logic             is_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign start     = (state == IDLE) && bus.op_valid;
  assign div_req   = bus.op_code[1];
  assign zero_div  = start && div_req && (bus.op_b == '0);
  assign is_signed = ~bus.op_code[0];
  assign sign_a    = is_signed & bus.op_a[WIDTH-1];
  assign sign_b    = is_signed & bus.op_b[WIDTH-1];
  assign mag_a     = sign_a ? -bus.op_a : bus.op_a;
  assign mag_b     = sign_b ? -bus.op_b : bus.op_b;

  // Multiply keeps {partial product, remaining multiplier bits} in acc_hi:acc_lo;
  // divide keeps {partial remainder, dividend bits becoming quotient bits}.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, opnd};
  assign div_rem   = div_trial[WIDTH-1:0] - opnd;

  assign prod      = {acc_hi, acc_lo};
  assign prod_fix  = neg_q ? -prod : prod;
  assign quo_fix   = neg_q ? -acc_lo : acc_lo;
  assign rem_fix   = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !zero_div) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (zero_div) begin
            done_q <= 1'b1;
            dz_q   <= 1'b1;
          end else if (start) begin
            cnt    <= '0;
            is_div <= div_req;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            acc_hi <= '0;
            if (div_req) begin
              acc_lo <= mag_a;
              opnd   <= mag_b;
            end else begin
              acc_lo <= mag_b;
              opnd   <= mag_a;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            acc_hi <= div_ge ? div_rem : div_trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.hilo_stall = bus.busy & bus.id_uses_hilo;
  assign bus.done       = done_q;
  assign bus.div_zero   = dz_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [64:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, q, r;
    logic [31:0] uq, ur;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    case (c)
      2'b00: return sa * sbv;
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      default: begin
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_hilo, input int inject_at);
    logic [64:0] exp;
    logic [64:0] got;
    int cycles, busy_cnt, stall_cnt, exp_busy;
    bit hold_ok;
    if (c[1] && b == 32'd0) exp = {1'b1, m_hi, m_lo};
    else                    exp = {1'b0, exp_hilo};
    sb.push_back(exp);
    exp_busy = exp[64] ? 0 : 33;

    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = c;
    bus.op_a     = a;
    bus.op_b     = b;
    @(negedge clk);
    bus.op_valid = 1'b0;
    cycles = 0; busy_cnt = 0; stall_cnt = 0; hold_ok = 1'b1;
    while (bus.done !== 1'b1 && cycles < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.hilo_stall === 1'b1) stall_cnt++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) hold_ok = 1'b0;
      if (cycles == inject_at) begin
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b01;
        bus.op_a     = a ^ 32'h5a5a_0f0f;
        bus.op_b     = b + 32'd9;
      end else begin
        bus.op_valid = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    bus.op_valid = 1'b0;

    check({tag, " done_seen"}, bus.done, 1'b1);
    got = sb.pop_front();
    check({tag, " hi"}, bus.hi, got[63:32]);
    check({tag, " lo"}, bus.lo, got[31:0]);
    check({tag, " div_zero"}, bus.div_zero, got[64]);
    check({tag, " latency"}, cycles, exp_busy);
    check({tag, " busy_cycles"}, busy_cnt, exp_busy);
    check({tag, " busy_in_done"}, bus.busy, 1'b0);
    check({tag, " stall_in_done"}, bus.hilo_stall, 1'b0);
    check({tag, " stall_cycles"}, stall_cnt, bus.id_uses_hilo ? exp_busy : 0);
    check({tag, " hilo_held"}, hold_ok, 1'b1);
    m_hi = got[63:32];
    m_lo = got[31:0];
    @(negedge clk);
    check({tag, " done_pulse"}, bus.done, 1'b0);
    check({tag, " dz_pulse"}, bus.div_zero, 1'b0);
    check({tag, " hilo_after"}, {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  initial begin
    bus.op_valid     = 1'b0;
    bus.op_code      = 2'b00;
    bus.op_a         = '0;
    bus.op_b         = '0;
    bus.id_uses_hilo = 1'b0;
    repeat (2) @(negedge clk);
    check("rst hi", bus.hi, 32'h0);
    check("rst lo", bus.lo, 32'h0);
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    check("rst div_zero", bus.div_zero, 1'b0);
    check("rst stall", bus.hilo_stall, 1'b0);
    rst_n = 1'b1;

    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, -1);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, -1);
    run_op("div_minneg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, -1);
    run_op("preload", 2'b11, 32'h5678_1234, 32'h0001_0000, 64'h0000_1234_0000_5678, -1);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 64'h0, -1);

    bus.id_uses_hilo = 1'b1;
    run_op("stall_mult", 2'b00, 32'h0000_1234, 32'hFFFF_FFFE, model(2'b00, 32'h0000_1234, 32'hFFFF_FFFE), 10);
    bus.id_uses_hilo = 1'b0;

    run_op("div_100_n7", 2'b10, 32'd100, 32'hFFFF_FFF9, model(2'b10, 32'd100, 32'hFFFF_FFF9), -1);
    run_op("divu_max_3", 2'b11, 32'hFFFF_FFFF, 32'd3, model(2'b11, 32'hFFFF_FFFF, 32'd3), -1);
    run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, model(2'b00, 32'h8000_0000, 32'h8000_0000), -1);
    run_op("div_n100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, model(2'b10, 32'hFFFF_FF9C, 32'd7), -1);
    run_op("divu_small", 2'b11, 32'd3, 32'd10, model(2'b11, 32'd3, 32'd10), -1);

    bus.id_uses_hilo = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 2'b10;
    bus.op_a     = 32'd1000;
    bus.op_b     = 32'd7;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async busy", bus.busy, 1'b0);
    check("async hi", bus.hi, 32'h0);
    check("async lo", bus.lo, 32'h0);
    check("async stall", bus.hilo_stall, 1'b0);
    m_hi = '0;
    m_lo = '0;
    bus.id_uses_hilo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_multu", 2'b01, 32'd3, 32'd4, 64'h0000_0000_0000_000C, -1);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller and datapath for MIPS MULT/MULTU/DIV/DIVU and the HI/LO registers. It sits beside the EX stage. It accepts one operation from EX, iterates one bit per clock (shift-add for multiply, restoring division for divide), and writes HI/LO on completion. While busy it raises a stall request that the hazard unit ORs into its PC/IF-ID hold and control-mux bubble logic.

## Interface
- WIDTH, 32, operand and HI/LO width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- op_valid  in  1  EX-stage instruction is a mult/div; sampled only in IDLE.
- op_code  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- op_a  in  WIDTH  rs value (multiplicand / dividend).
- op_b  in  WIDTH  rt value (multiplier / divisor).
- id_uses_hilo  in  1  ID-stage instruction is MFHI, MFLO, MULT, MULTU, DIV or DIVU.
- busy  out  1  operation in progress.
- hilo_stall  out  1  stall request to the hazard unit: busy & id_uses_hilo.
- done  out  1  one-cycle pulse when HI/LO are updated, or when a divide by zero is aborted.
- div_zero  out  1  one-cycle pulse, coincident with done, for DIV/DIVU with op_b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**:
  - On op_valid, latch the op type and signedness.
  - Signed ops convert operands to magnitudes and record the result signs:
    - Product sign = sign_a ^ sign_b.
    - Quotient sign = sign_a ^ sign_b.
    - Remainder sign = sign_a.
  - Load the working registers, set iteration counter = 0, go to RUN.
  - Divide with op_b == 0: stay in IDLE. Pulse done and div_zero on the next cycle. HI/LO unchanged.
- **RUN**: one iteration per clock. Counter increments; after iteration WIDTH-1, go to FIX.
  - Multiply: 2*WIDTH-bit accumulator, LSB-first shift-add of the op_a magnitude.
  - Divide: restoring. Remainder shifts left one bit and takes the next dividend bit. If remainder ≥ divisor, subtract and the quotient bit is 1.
- **FIX**: apply two's-complement negation per the recorded signs, write HI/LO, pulse done, go to IDLE.
  - Multiply: {hi,lo} = 2*WIDTH-bit product.
  - Divide: lo = quotient, hi = remainder.
- Arithmetic:
  - Multiply is exact in 2*WIDTH bits.
  - DIV of most-negative by -1 gives magnitude 2^(WIDTH-1). Negating truncates it to WIDTH bits: lo = 0x80000000, hi = 0.
- op_valid while not in IDLE is ignored. The pipeline guarantees this never happens via hilo_stall; the bench checks that it is ignored.
- hi/lo change only in the FIX cycle. They are readable at all other times.
- hilo_stall is combinational from registered busy and the id_uses_hilo input.

## Timing
- Reset (async, immediate): state IDLE, counter 0, busy 0, done 0, div_zero 0, hi 0, lo 0, hilo_stall 0. Reset asserted mid-RUN aborts the op; there is no HI/LO write.
- Normal op, with op_valid sampled at edge E0:
  - busy = 1 from E0 through E(WIDTH+1).
  - FIX occupies the cycle after E(WIDTH).
  - hi/lo and done update at E(WIDTH+1), with done high for one cycle.
  - busy = 0 after E(WIDTH+1).
  - Total latency WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: busy stays 0. done and div_zero are high for the one cycle after E0.
- A new op_valid is accepted in the same cycle done is high (state is IDLE).
- An MFHI/MFLO in ID during the done cycle is not stalled and reads the new hi/lo through the register file bypass.

## Test plan
- **Signed multiply**: MULT op_a=0xFFFFFFFD (-3), op_b=7 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, one done pulse, busy high exactly 33 cycles.
- **Unsigned multiply**: MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- **Signed divide**:
  - DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- **Divide by zero**: DIVU 5/0 with hi/lo preloaded 0x1234/0x5678 → done and div_zero high for one cycle, busy never high, hi/lo unchanged.
- **Stall request**: id_uses_hilo=1 throughout a MULT → hilo_stall=1 for all 33 busy cycles and 0 in the done cycle. A second op_valid mid-RUN leaves the result unchanged.
- **Reset mid-operation**: rst_n low at cycle 10 of a DIV → busy, hi and lo read 0 immediately, without waiting for a clock edge. After release, a new MULTU 3×4 gives lo=12, hi=0.
